// File: rtl/bus_arbiter.sv
// Two-requester memory bus arbiter: EU operand accesses win by fixed priority,
// instruction prefetch is forced through after STARVE_MAX consecutive EU grants
// while it waits. Each access is IDLE -> ACCESS (wait states, timeout) -> DONE.
module bus_arbiter #(
    parameter int AW         = 20,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          eu_req,
    input  logic          eu_we,
    input  logic [AW-1:0] eu_addr,
    input  logic [DW-1:0] eu_wdata,
    output logic          eu_ready,
    output logic [DW-1:0] eu_rdata,
    input  logic          pf_req,
    input  logic [AW-1:0] pf_addr,
    output logic          pf_ready,
    output logic [DW-1:0] pf_rdata,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [1:0]    grant,
    output logic          err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [SW-1:0]  r_starve;
    logic [WW-1:0]  r_wait;
    logic           r_win_pf;
    logic           r_we;
    logic           r_err;
    logic [AW-1:0]  r_addr;
    logic [DW-1:0]  r_wdata;
    logic [DW-1:0]  r_eu_rdata;
    logic [DW-1:0]  r_pf_rdata;

    logic w_pick_pf;
    logic w_pick_eu;
    logic w_timeout;

    // Prefetch only wins when the EU is idle or the EU has used up its streak.
    assign w_pick_pf = pf_req && (!eu_req || (r_starve == SW'(STARVE_MAX)));
    assign w_pick_eu = eu_req && !w_pick_pf;
    assign w_timeout = (r_wait == WW'(TIMEOUT - 1));

    // State register; reset abandons any transaction without a ready pulse.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode and bus/handshake outputs, all derived from state.
    always_comb begin
        w_next    = r_state;
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        grant     = 2'b00;
        eu_ready  = 1'b0;
        pf_ready  = 1'b0;
        err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_pf || w_pick_eu) w_next = S_ACCESS;
            end
            S_ACCESS: begin
                mem_cs    = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                grant     = r_win_pf ? 2'b10 : 2'b01;
                if (mem_ack || w_timeout) w_next = S_DONE;
            end
            S_DONE: begin
                grant    = r_win_pf ? 2'b10 : 2'b01;
                eu_ready = !r_win_pf;
                pf_ready = r_win_pf;
                err      = r_err;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Grant bookkeeping: winner, direction, starvation streak, wait counter, timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
            r_wait   <= '0;
            r_err    <= 1'b0;
            r_win_pf <= 1'b0;
            r_we     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_pf || w_pick_eu) begin
                        r_win_pf <= w_pick_pf;
                        r_we     <= w_pick_eu && eu_we;
                        r_wait   <= '0;
                        r_err    <= 1'b0;
                        if (w_pick_eu && pf_req) begin
                            if (r_starve != SW'(STARVE_MAX)) r_starve <= r_starve + SW'(1);
                        end else begin
                            r_starve <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!mem_ack) begin
                        if (w_timeout) r_err  <= 1'b1;
                        else           r_wait <= r_wait + WW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Address/write-data latch; only observable on the bus during ACCESS.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE) begin
            r_addr  <= w_pick_pf ? pf_addr : eu_addr;
            r_wdata <= w_pick_pf ? '0 : eu_wdata;
        end
    end

    // Per-requester read data: updated only by the winner's read, zeroed on timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_eu_rdata <= '0;
            r_pf_rdata <= '0;
        end else if (r_state == S_ACCESS && !r_we && (mem_ack || w_timeout)) begin
            if (r_win_pf) r_pf_rdata <= mem_ack ? mem_rdata : '0;
            else          r_eu_rdata <= mem_ack ? mem_rdata : '0;
        end
    end

    assign eu_rdata = r_eu_rdata;
    assign pf_rdata = r_pf_rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: cycle-by-cycle vector table for the basic
// read/write/drop cases, plus hand sequences for starvation, timeout and reset.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        eu_req, eu_we, pf_req, mem_ack;
    logic [19:0] eu_addr, pf_addr;
    logic [15:0] eu_wdata, mem_rdata;
    logic        eu_ready, pf_ready, mem_cs, mem_we, err;
    logic [15:0] eu_rdata, pf_rdata, mem_wdata;
    logic [19:0] mem_addr;
    logic [1:0]  grant;

    int n_chk = 0;
    int n_err = 0;

    bus_arbiter #(.AW(20), .DW(16), .STARVE_MAX(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .eu_req(eu_req), .eu_we(eu_we), .eu_addr(eu_addr), .eu_wdata(eu_wdata),
        .eu_ready(eu_ready), .eu_rdata(eu_rdata),
        .pf_req(pf_req), .pf_addr(pf_addr), .pf_ready(pf_ready), .pf_rdata(pf_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .grant(grant), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst, eu_req, eu_we;
        logic [19:0] eu_addr;
        logic [15:0] eu_wdata;
        logic        pf_req;
        logic [19:0] pf_addr;
        logic        mem_ack;
        logic [15:0] mem_rdata;
        logic        cs, we;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [1:0]  grant;
        logic        eu_rdy;
        logic [15:0] eu_rd;
        logic        pf_rdy;
        logic [15:0] pf_rd;
        logic        err;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Both requesters held high with immediate ack; streak pattern assumes starve=0 on entry.
    task automatic run_both(input int n, input string tag);
        logic exp_pf;
        for (int t = 0; t < n; t++) begin
            exp_pf    = ((t % 5) == 4);
            eu_req    = 1'b1;
            pf_req    = 1'b1;
            eu_we     = 1'b0;
            eu_addr   = 20'h11111;
            pf_addr   = 20'h22222;
            mem_ack   = 1'b1;
            mem_rdata = 16'h1000 + 16'(t);
            samp();
            chk($sformatf("%s t%0d idle grant", tag, t), 32'(grant), 32'd0);
            tick();
            samp();
            chk($sformatf("%s t%0d grant", tag, t), 32'(grant), exp_pf ? 32'd2 : 32'd1);
            chk($sformatf("%s t%0d addr", tag, t), 32'(mem_addr), exp_pf ? 32'h22222 : 32'h11111);
            tick();
            if (t == n - 1) begin
                eu_req = 1'b0;
                pf_req = 1'b0;
            end
            samp();
            chk($sformatf("%s t%0d eu_ready", tag, t), 32'(eu_ready), 32'(!exp_pf));
            chk($sformatf("%s t%0d pf_ready", tag, t), 32'(pf_ready), 32'(exp_pf));
            chk($sformatf("%s t%0d err", tag, t), 32'(err), 32'd0);
            chk($sformatf("%s t%0d rdata", tag, t), exp_pf ? 32'(pf_rdata) : 32'(eu_rdata),
                32'h1000 + 32'(t));
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; eu_req = 1'b0; eu_we = 1'b0; pf_req = 1'b0; mem_ack = 1'b0;
        eu_addr = '0; pf_addr = '0; eu_wdata = '0; mem_rdata = '0;

        // rst eu_req eu_we eu_addr eu_wdata pf_req pf_addr ack rdata | cs we addr wdata grant eu_rdy eu_rd pf_rdy pf_rd err
        vt[0]  = '{1'b1,1'b0,1'b0,20'h0,16'h0,1'b0,20'h0,1'b0,16'h0,     1'b0,1'b0,20'h0,16'h0,2'b00,1'b0,16'h0,1'b0,16'h0,1'b0};
        vt[1]  = '{1'b1,1'b0,1'b0,20'h0,16'h0,1'b0,20'h0,1'b1,16'h5555,  1'b0,1'b0,20'h0,16'h0,2'b00,1'b0,16'h0,1'b0,16'h0,1'b0};
        // EU read, two wait states
        vt[2]  = '{1'b0,1'b1,1'b0,20'h12345,16'h0,1'b0,20'h0,1'b0,16'h0, 1'b0,1'b0,20'h0,16'h0,2'b00,1'b0,16'h0,1'b0,16'h0,1'b0};
        vt[3]  = '{1'b0,1'b1,1'b0,20'h12345,16'h0,1'b0,20'h0,1'b0,16'h0, 1'b1,1'b0,20'h12345,16'h0,2'b01,1'b0,16'h0,1'b0,16'h0,1'b0};
        vt[4]  = '{1'b0,1'b1,1'b0,20'h12345,16'h0,1'b0,20'h0,1'b0,16'h0, 1'b1,1'b0,20'h12345,16'h0,2'b01,1'b0,16'h0,1'b0,16'h0,1'b0};
        vt[5]  = '{1'b0,1'b1,1'b0,20'h12345,16'h0,1'b0,20'h0,1'b1,16'hBEEF, 1'b1,1'b0,20'h12345,16'h0,2'b01,1'b0,16'h0,1'b0,16'h0,1'b0};
        vt[6]  = '{1'b0,1'b0,1'b0,20'h0,16'h0,1'b0,20'h0,1'b1,16'hDEAD,  1'b0,1'b0,20'h0,16'h0,2'b01,1'b1,16'hBEEF,1'b0,16'h0,1'b0};
        vt[7]  = '{1'b0,1'b0,1'b0,20'h0,16'h0,1'b0,20'h0,1'b1,16'hDEAD,  1'b0,1'b0,20'h0,16'h0,2'b00,1'b0,16'hBEEF,1'b0,16'h0,1'b0};
        // EU write, zero wait; read data must not move
        vt[8]  = '{1'b0,1'b1,1'b1,20'h00ABC,16'hA5A5,1'b0,20'h0,1'b1,16'hDEAD, 1'b0,1'b0,20'h0,16'h0,2'b00,1'b0,16'hBEEF,1'b0,16'h0,1'b0};
        vt[9]  = '{1'b0,1'b1,1'b1,20'h00ABC,16'hA5A5,1'b0,20'h0,1'b1,16'hDEAD, 1'b1,1'b1,20'h00ABC,16'hA5A5,2'b01,1'b0,16'hBEEF,1'b0,16'h0,1'b0};
        vt[10] = '{1'b0,1'b0,1'b0,20'h0,16'h0,1'b0,20'h0,1'b1,16'hDEAD,  1'b0,1'b0,20'h0,16'h0,2'b01,1'b1,16'hBEEF,1'b0,16'h0,1'b0};
        vt[11] = '{1'b0,1'b0,1'b0,20'h0,16'h0,1'b0,20'h0,1'b1,16'hDEAD,  1'b0,1'b0,20'h0,16'h0,2'b00,1'b0,16'hBEEF,1'b0,16'h0,1'b0};
        // Prefetch read with request dropped mid-ACCESS
        vt[12] = '{1'b0,1'b0,1'b0,20'h0,16'h0,1'b1,20'h54321,1'b0,16'h0, 1'b0,1'b0,20'h0,16'h0,2'b00,1'b0,16'hBEEF,1'b0,16'h0,1'b0};
        vt[13] = '{1'b0,1'b0,1'b0,20'h0,16'h0,1'b1,20'h54321,1'b0,16'h0, 1'b1,1'b0,20'h54321,16'h0,2'b10,1'b0,16'hBEEF,1'b0,16'h0,1'b0};
        vt[14] = '{1'b0,1'b0,1'b0,20'h0,16'h0,1'b0,20'h54321,1'b0,16'h0, 1'b1,1'b0,20'h54321,16'h0,2'b10,1'b0,16'hBEEF,1'b0,16'h0,1'b0};
        vt[15] = '{1'b0,1'b0,1'b0,20'h0,16'h0,1'b0,20'h54321,1'b1,16'h1234, 1'b1,1'b0,20'h54321,16'h0,2'b10,1'b0,16'hBEEF,1'b0,16'h0,1'b0};
        vt[16] = '{1'b0,1'b0,1'b0,20'h0,16'h0,1'b0,20'h0,1'b0,16'h0,     1'b0,1'b0,20'h0,16'h0,2'b10,1'b0,16'hBEEF,1'b1,16'h1234,1'b0};
        vt[17] = '{1'b0,1'b0,1'b0,20'h0,16'h0,1'b0,20'h0,1'b0,16'h0,     1'b0,1'b0,20'h0,16'h0,2'b00,1'b0,16'hBEEF,1'b0,16'h1234,1'b0};

        for (int i = 0; i < NV; i++) begin
            rst = vt[i].rst; eu_req = vt[i].eu_req; eu_we = vt[i].eu_we;
            eu_addr = vt[i].eu_addr; eu_wdata = vt[i].eu_wdata;
            pf_req = vt[i].pf_req; pf_addr = vt[i].pf_addr;
            mem_ack = vt[i].mem_ack; mem_rdata = vt[i].mem_rdata;
            samp();
            chk($sformatf("v%0d mem_cs", i),    32'(mem_cs),    32'(vt[i].cs));
            chk($sformatf("v%0d mem_we", i),    32'(mem_we),    32'(vt[i].we));
            chk($sformatf("v%0d mem_addr", i),  32'(mem_addr),  32'(vt[i].addr));
            chk($sformatf("v%0d mem_wdata", i), 32'(mem_wdata), 32'(vt[i].wdata));
            chk($sformatf("v%0d grant", i),     32'(grant),     32'(vt[i].grant));
            chk($sformatf("v%0d eu_ready", i),  32'(eu_ready),  32'(vt[i].eu_rdy));
            chk($sformatf("v%0d eu_rdata", i),  32'(eu_rdata),  32'(vt[i].eu_rd));
            chk($sformatf("v%0d pf_ready", i),  32'(pf_ready),  32'(vt[i].pf_rdy));
            chk($sformatf("v%0d pf_rdata", i),  32'(pf_rdata),  32'(vt[i].pf_rd));
            chk($sformatf("v%0d err", i),       32'(err),       32'(vt[i].err));
            tick();
        end

        // Starvation: EU x4 then PF, twice
        run_both(10, "starve");

        // Timeout on a prefetch read
        eu_req = 1'b0; pf_req = 1'b1; pf_addr = 20'h0F0F0; mem_ack = 1'b0;
        samp();
        chk("to idle cs", 32'(mem_cs), 32'd0);
        tick();
        for (int k = 0; k < 15; k++) begin
            samp();
            chk($sformatf("to cs c%0d", k + 1), 32'(mem_cs), 32'd1);
            chk($sformatf("to grant c%0d", k + 1), 32'(grant), 32'd2);
            tick();
        end
        pf_req = 1'b0;
        samp();
        chk("to pf_ready", 32'(pf_ready), 32'd1);
        chk("to err", 32'(err), 32'd1);
        chk("to pf_rdata", 32'(pf_rdata), 32'd0);
        chk("to done cs", 32'(mem_cs), 32'd0);
        tick();
        samp();
        chk("to after err", 32'(err), 32'd0);
        chk("to after grant", 32'(grant), 32'd0);
        chk("to after pf_ready", 32'(pf_ready), 32'd0);
        tick();

        // Reset during the third ACCESS cycle with a starve streak of 3
        run_both(2, "pre");
        eu_req = 1'b1; pf_req = 1'b1; eu_we = 1'b0; eu_addr = 20'h33333; mem_ack = 1'b0;
        samp();
        chk("rs idle grant", 32'(grant), 32'd0);
        tick();
        samp();
        chk("rs acc1 grant", 32'(grant), 32'd1);
        tick();
        samp();
        tick();
        rst = 1'b1;
        samp();
        chk("rs acc3 cs", 32'(mem_cs), 32'd1);
        tick();
        rst = 1'b0; eu_req = 1'b0; pf_req = 1'b0;
        samp();
        chk("rs after cs", 32'(mem_cs), 32'd0);
        chk("rs after grant", 32'(grant), 32'd0);
        chk("rs after eu_ready", 32'(eu_ready), 32'd0);
        chk("rs after pf_ready", 32'(pf_ready), 32'd0);
        chk("rs after eu_rdata", 32'(eu_rdata), 32'd0);
        tick();
        samp();
        chk("rs idle eu_ready", 32'(eu_ready), 32'd0);
        tick();
        run_both(5, "post");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
